controller_stage_n: RTL
=======================

# controller_stage_n

Parametrised sequencing controller for one buffered stage of the transform pipeline. It fills NUM_FIFO sample FIFOs in order through a demux tree, then drains them either one FIFO at a time or in even/odd pairs for the butterfly datapath, and pulses `done` at block end. It replaces the fixed 4-FIFO stage controller. It adds valid/ready flow control, a run-time read mode, and synchronous flush.

## Interface
- NUM_FIFO, 4, number of stage FIFOs; power of two, ≥2
- FIFO_DEPTH, 8, samples per FIFO per block; power of two, ≥2
- SEL_W, clog2(NUM_FIFO), width of select buses
- clk  in  1  stage clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a block; sampled only in IDLE
- mode  in  1  read mode, latched at start: 0 = sequential, 1 = paired
- flush  in  1  synchronous abort to IDLE, priority over all else except rst
- in_valid  in  1  input sample present this cycle
- out_ready  in  1  downstream accepts a FIFO pop this cycle
- write_fifo  out  NUM_FIFO  push strobes, at most one high
- read_fifo  out  NUM_FIFO  pop strobes
- sel_demux  out  SEL_W  demux route = FIFO index being written
- sel_mux  out  SEL_W  output mux select = FIFO index (mode 0) or pair index (mode 1)
- busy  out  1  high in WRITE, READ, DONE
- done  out  1  one-cycle end-of-block pulse

## Operation
- TOTAL = NUM_FIFO·FIFO_DEPTH. Counters are wr_cnt and rd_cnt, each clog2(TOTAL) bits. There is also mode_q.
- States: IDLE, WRITE, READ, DONE. State, counters and mode_q are registered. Strobes are combinational from registered state plus in_valid/out_ready.
- IDLE
  - start=1 → WRITE; wr_cnt←0, rd_cnt←0, mode_q←mode.
- WRITE
  - wr_idx = wr_cnt / FIFO_DEPTH.
  - sel_demux = wr_idx.
  - write_fifo = onehot(wr_idx) & in_valid.
  - wr_cnt increments on in_valid.
  - in_valid with wr_cnt=TOTAL−1 → READ.
- READ, mode_q=0
  - Last count is TOTAL−1.
  - j = rd_cnt / FIFO_DEPTH.
  - read_fifo = onehot(j) & out_ready.
  - sel_mux = j.
- READ, mode_q=1
  - Last count is TOTAL/2−1.
  - j = rd_cnt / FIFO_DEPTH.
  - read_fifo bits 2j and 2j+1 = out_ready.
  - sel_mux = j.
- READ, both modes
  - rd_cnt increments on out_ready.
  - out_ready at the last count → DONE.
- DONE
  - done=1 for exactly one cycle → IDLE. start is ignored in DONE.
- start outside IDLE is ignored. mode changes after start have no effect.
- flush=1 on any edge: state←IDLE and counters←0, next cycle. Strobes are already low in the cycle after flush, and FIFO contents are the datapath's concern.
- Outside the active state:
  - write_fifo=0 outside WRITE.
  - read_fifo=0 outside READ.
  - sel_demux=0 outside WRITE.
  - sel_mux=0 outside READ.
- Counters never wrap inside a block; the phase ends at the last count.

## Timing
- Reset (rst=0, asynchronous):
  - state IDLE, counters 0.
  - All outputs 0.
  - Deassertion is synchronised by the top level.
- Continuous in_valid and out_ready, start sampled at edge 0, defaults:
  - WRITE occupies cycles 1–32; write_fifo[k] is high in cycles 8k+1 … 8k+8.
  - READ occupies cycles 33–64 in mode 0, or 33–48 in mode 1.
  - done is high in cycle 65 (mode 0) or 49 (mode 1).
  - IDLE follows the next cycle; busy drops with it.
- The earliest restart is start sampled in the first IDLE cycle after DONE.
- Stalls: in_valid=0 or out_ready=0 freezes the counter and deasserts strobes that cycle. sel_demux and sel_mux hold their value.
- Zero added latency from in_valid to write_fifo and from out_ready to read_fifo; both are combinational.
- The transition on the last write/read takes effect on that same edge. There is no idle bubble between WRITE and READ.

## Test plan
- Reset during WRITE at wr_cnt=13 (rst low mid-cycle) → all outputs 0 immediately; after release, IDLE with busy=0, and the next start restarts at write_fifo[0].
- Default parameters, mode=0, continuous valid/ready → 32 single-hot writes in order FIFO0..3, 8 each, then 32 single-hot reads in the same order; done exactly at cycle 65; sel_demux and sel_mux track the index.
- Mode=1, same stimulus → reads assert 4'b0011 for 8 cycles then 4'b1100 for 8 cycles; sel_mux 0 then 1; done at cycle 49; mode toggled after start has no effect.
- Random in_valid/out_ready at 50% → exactly 32 write strobes and 32 (mode 0) or 16 (mode 1) read strobes; no strobe while the corresponding valid/ready is low; done pulse width 1.
- flush asserted at read count 5, start held high throughout → state IDLE next cycle, no further strobes, done never pulses; start in the following IDLE cycle begins a new block; start pulses during WRITE/READ are ignored.
- NUM_FIFO=8, FIFO_DEPTH=4 → SEL_W=3; 32 writes visit FIFO0..7 for 4 cycles each; mode-1 reads visit pairs 0..3 for 4 cycles each.

Source files
------------

// File: rtl/controller_stage_n.sv
// Sequencing controller for one buffered transform stage: fills NUM_FIFO FIFOs in
// order, then drains them singly (mode 0) or as even/odd pairs (mode 1).
module controller_stage_n #(
  parameter  int NUM_FIFO   = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int SEL_W      = $clog2(NUM_FIFO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic [NUM_FIFO-1:0] write_fifo,
  output logic [NUM_FIFO-1:0] read_fifo,
  output logic [SEL_W-1:0]    sel_demux,
  output logic [SEL_W-1:0]    sel_mux,
  output logic                busy,
  output logic                done
);

  localparam int TOTAL = NUM_FIFO * FIFO_DEPTH;
  localparam int CNT_W = $clog2(TOTAL);
  localparam int DEP_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_SEQ  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(TOTAL / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             mode_q, mode_d;

  logic [SEL_W-1:0] wr_idx, rd_idx;
  logic             wr_last, rd_last;

  // The upper counter bits are the FIFO (or pair) index since FIFO_DEPTH is a power of two.
  assign wr_idx  = wr_cnt_q[CNT_W-1:DEP_W];
  assign rd_idx  = rd_cnt_q[CNT_W-1:DEP_W];
  assign wr_last = (wr_cnt_q == LAST_SEQ);
  assign rd_last = (rd_cnt_q == (mode_q ? LAST_PAIR : LAST_SEQ));

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mode_d   = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WRITE;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          mode_d   = mode;
        end
      end
      S_WRITE: begin
        if (in_valid) begin
          if (wr_last) state_d = S_READ;
          else         wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (out_ready) begin
          if (rd_last) state_d = S_DONE;
          else         rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      mode_q   <= mode_d;
    end
  end

  // Strobes are gated directly by in_valid/out_ready so a stall costs no latency.
  always_comb begin
    write_fifo = '0;
    read_fifo  = '0;
    sel_demux  = '0;
    sel_mux    = '0;
    if (state_q == S_WRITE) begin
      sel_demux = wr_idx;
      for (int k = 0; k < NUM_FIFO; k++)
        write_fifo[k] = in_valid && (wr_idx == SEL_W'(k));
    end
    if (state_q == S_READ) begin
      sel_mux = rd_idx;
      for (int k = 0; k < NUM_FIFO; k++)
        read_fifo[k] = out_ready &&
                       (mode_q ? (rd_idx == SEL_W'(k / 2)) : (rd_idx == SEL_W'(k)));
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
